// File: rtl/cb_cfg_pkg.sv
// Shared types and tap-geometry helpers for the X-channel connection block.
//   cfg_state_e : configuration FSM states
//   tap_track() : channel track feeding tap j of ipin i
//   tap_side()  : which direction a tap is taken from (0 = left_in, 1 = right_in)
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ARMED  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    // Tap pairs step across the channel by 'stride' tracks, offset by the ipin index.
    function automatic int tap_track(int i, int j, int stride, int chan_w);
        return (i + (j / 2) * stride) % chan_w;
    endfunction

    function automatic bit tap_side(int j);
        return (j % 2) == 1;
    endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// One grid-input-pin multiplexer.
//   in_i  : MUX_SIZE candidate taps
//   sel_i : tap select; codes >= MUX_SIZE route nothing (output 0)
//   out_o : selected tap
module cb_ipin_mux #(
    parameter int MUX_SIZE = 6,
    parameter int SEL_W    = 3
) (
    input  logic [MUX_SIZE-1:0] in_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic                out_o
);

    // Explicit decode keeps out-of-range selects at 0 without an out-of-bounds index.
    always_comb begin
        out_o = 1'b0;
        for (int j = 0; j < MUX_SIZE; j++) begin
            if (sel_i == SEL_W'(j)) begin
                out_o = in_i[j];
            end
        end
    end

endmodule

// File: rtl/cbx_param_cfgchain.sv
// X-channel connection block with a double-buffered serial configuration chain.
//   prog_clk / prog_reset       : clock, synchronous active-high reset
//   chanx_left_in/right_in      : channel tracks; passed straight through to the opposite side
//   ipin_out                    : routed grid input pins (0 until the first commit)
//   ccff_head / ccff_tail       : serial config in / registered shadow MSB out
//   cfg_en / cfg_commit         : shift strobe / shadow->active copy request
//   cfg_done / cfg_err          : commit pulse / sticky premature-commit flag
//
// state  | meaning
// IDLE   | no load in progress, counter at 0
// SHIFT  | partial load, fewer than CFG_BITS bits shifted
// ARMED  | full load in shadow, waiting for commit
// COMMIT | active just loaded, cfg_done high, counter clears
module cbx_param_cfgchain
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W   = 9,
    parameter int N_IPIN   = 8,
    parameter int MUX_SIZE = 6,
    parameter int STRIDE   = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] chanx_right_in,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic [CHAN_W-1:0] chanx_right_out,
    output logic [N_IPIN-1:0] ipin_out,
    input  logic              ccff_head,
    input  logic              cfg_en,
    input  logic              cfg_commit,
    output logic              ccff_tail,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int SEL_W    = $clog2(MUX_SIZE);
    localparam int CFG_BITS = N_IPIN * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    cfg_state_e          state_q, state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    // Set by a commit and held while cfg_commit stays high, so a held request
    // neither commits twice nor counts as a premature commit.
    logic                hold_q, hold_d;
    logic [N_IPIN-1:0]   mux_out;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;
    assign ccff_tail       = shadow_q[CFG_BITS-1];
    assign cfg_done        = (state_q == COMMIT);
    assign cfg_err         = err_q;
    assign ipin_out        = mux_out & {N_IPIN{valid_q}};

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        hold_d   = hold_q & cfg_commit;

        if (cfg_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
            if (cnt_q != CNT_W'(CFG_BITS)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE, SHIFT: begin
                if (cfg_en) begin
                    state_d = (cnt_d == CNT_W'(CFG_BITS)) ? ARMED : SHIFT;
                end else if (cfg_commit && !hold_q) begin
                    err_d = 1'b1;
                end
            end
            ARMED: begin
                // Copy on entry to COMMIT so routing switches in the same cycle cfg_done pulses.
                if (cfg_commit && !cfg_en) begin
                    state_d  = COMMIT;
                    active_d = shadow_q;
                    valid_d  = 1'b1;
                    hold_d   = 1'b1;
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    for (genvar i = 0; i < N_IPIN; i++) begin : g_ipin
        logic [MUX_SIZE-1:0] taps;
        for (genvar j = 0; j < MUX_SIZE; j++) begin : g_tap
            localparam int TRK = tap_track(i, j, STRIDE, CHAN_W);
            if (tap_side(j)) begin : g_right
                assign taps[j] = chanx_right_in[TRK];
            end else begin : g_left
                assign taps[j] = chanx_left_in[TRK];
            end
        end
        cb_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .in_i  (taps),
            .sel_i (active_q[i*SEL_W +: SEL_W]),
            .out_o (mux_out[i])
        );
    end

endmodule
